// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: word width, access size codes, FSM states
// and the misalignment rule.
package lsu_pkg;

    localparam int unsigned WordLen = 32;

    typedef enum logic [1:0] {
        SzB = 2'b00,
        SzH = 2'b01,
        SzW = 2'b10,
        SzR = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StData = 3'd2,
        StWr   = 3'd3,
        StErr  = 3'd4
    } lsu_state_e;

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        unique case (size)
            SzB:     return 1'b0;
            SzH:     return addr_lo[0];
            SzW:     return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit: extracts and extends sub-word loads, and merges
// sub-word store data into the word just read from memory.
module lsu_align import lsu_pkg::*; (
    input  logic [WordLen-1:0] rdata_i,
    input  logic [WordLen-1:0] store_data_i,
    input  logic [1:0]         addr_lo_i,
    input  lsu_size_e          size_i,
    input  logic               unsigned_i,
    output logic [WordLen-1:0] load_data_o,
    output logic [WordLen-1:0] merge_data_o
);

    logic [WordLen-1:0] shifted;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        ld_byte = shifted[7:0];
        // Halfword lane ignores addr[0]; misaligned halves are trapped upstream if enabled.
        ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (size_i)
            SzB:     load_data_o = {{24{~unsigned_i & ld_byte[7]}}, ld_byte};
            SzH:     load_data_o = {{16{~unsigned_i & ld_half[15]}}, ld_half};
            default: load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        merge_data_o = rdata_i;
        unique case (size_i)
            SzB:     merge_data_o[{addr_lo_i, 3'b000} +: 8] = store_data_i[7:0];
            SzH:     merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            default: merge_data_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: word-only memory port initiator with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses through the ERR state.
module lsu import lsu_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WordLen-1:0] req_addr,
    input  logic               req_wen,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WordLen-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [WordLen-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic [WordLen-1:0] addr_d,
    output logic               wen,
    output logic [WordLen-1:0] wdata,
    input  logic [WordLen-1:0] rdata
);

    lsu_state_e         state_q;
    logic [WordLen-1:0] addr_q;
    logic               store_q;
    lsu_size_e          size_q;
    logic               unsigned_q;
    logic [WordLen-1:0] wdata_q;
    logic               rsp_valid_q;
    logic [WordLen-1:0] rsp_rdata_q;
    logic               rsp_err_q;

    logic [WordLen-1:0] load_data;
    logic [WordLen-1:0] merge_data;

    lsu_align u_align (
        .rdata_i      (rdata),
        .store_data_i (wdata_q),
        .addr_lo_i    (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            store_q     <= 1'b0;
            size_q      <= SzB;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        store_q    <= req_wen;
                        size_q     <= lsu_size_e'(req_size);
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(lsu_size_e'(req_size), req_addr[1:0])) begin
                            state_q <= StErr;
                        end else
`endif
                        if (req_wen && req_size[1]) begin
                            state_q <= StWr;
                        end else begin
                            state_q <= StRd;
                        end
                    end
                end
                StRd: state_q <= StData;
                StData: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= store_q ? '0 : load_data;
                    state_q     <= StIdle;
                end
                StWr: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    state_q     <= StIdle;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                StErr: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                    state_q     <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    // State resets asynchronously, so wen falls as soon as rst_n does.
    assign wen       = (state_q == StWr) || ((state_q == StData) && store_q);
    assign wdata     = (state_q == StWr) ? wdata_q : merge_data;
    assign addr_d    = {addr_q[WordLen-1:2], 2'b00};
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a one-cycle registered word memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] addr_d;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (wen) mem[addr_d[9:2]] <= wdata;
        rdata <= mem[addr_d[9:2]];
    end

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .addr_d       (addr_d),
        .wen          (wen),
        .wdata        (wdata),
        .rdata        (rdata)
    );

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = byte_addr[9:2]; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request and reports latency from accept edge, write activity and response.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output int nwen, output logic [31:0] lastw,
                           output logic [31:0] rd, output logic er);
        @(negedge clk);
        req_valid = 1'b1; req_wen = we; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        lat = -1; nwen = 0; lastw = '0; rd = '0; er = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (wen) begin nwen++; lastw = wdata; end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (wen) begin nwen++; lastw = wdata; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (req_ready !== 1'b1 || wen !== 1'b0 || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: ready/wen/valid got %b%b%b want 100",
                     req_ready, wen, rsp_valid);
        end
        vecs++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || addr_d !== 32'h0) begin
            errs++;
            $display("FAIL reset_data: rdata %h err %b addr_d %h want 0 0 0",
                     rsp_rdata, rsp_err, addr_d);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        int lat, nwen; logic [31:0] lastw, rd; logic er;
        run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, nwen, lastw, rd, er);
        vecs++;
        if (lat !== 1 || nwen !== 1 || lastw !== 32'hDEADBEEF || rd !== 32'h0) begin
            errs++;
            $display("FAIL sw_word: lat %0d wen %0d wdata %h rdata %h want 1 1 deadbeef 0",
                     lat, nwen, lastw, rd);
        end
        @(posedge clk); #1;
        vecs++;
        if (rsp_valid !== 1'b0 || mem[8'h40] !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL sw_after: valid %b mem %h want 0 deadbeef", rsp_valid, mem[8'h40]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, nwen, lastw, rd, er);
        vecs++;
        if (lat !== 2 || nwen !== 0 || rd !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL lw_word: lat %0d wen %0d rdata %h want 2 0 deadbeef", lat, nwen, rd);
        end
    endtask

    task automatic test_store_merge();
        int lat, nwen; logic [31:0] lastw, rd; logic er;
        preload(32'h200, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA, lat, nwen, lastw, rd, er);
        vecs++;
        if (lat !== 2 || nwen !== 1 || lastw !== 32'h11AA3344 || rd !== 32'h0) begin
            errs++;
            $display("FAIL sb_merge: lat %0d wen %0d wdata %h rdata %h want 2 1 11aa3344 0",
                     lat, nwen, lastw, rd);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, nwen, lastw, rd, er);
        vecs++;
        if (rd !== 32'h11AA3344) begin
            errs++;
            $display("FAIL sb_reload: got %h want 11aa3344", rd);
        end
        run_req(1'b1, 2'b01, 1'b0, 32'h200, 32'h1234BEEF, lat, nwen, lastw, rd, er);
        vecs++;
        if (lat !== 2 || nwen !== 1 || lastw !== 32'h11AABEEF) begin
            errs++;
            $display("FAIL sh_merge_lo: lat %0d wen %0d wdata %h want 2 1 11aabeef",
                     lat, nwen, lastw);
        end
        run_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h00005A5A, lat, nwen, lastw, rd, er);
        vecs++;
        if (lastw !== 32'h5A5ABEEF || mem[8'h80] !== 32'h5A5ABEEF) begin
            errs++;
            $display("FAIL sh_merge_hi: wdata %h mem %h want 5a5abeef", lastw, mem[8'h80]);
        end
    endtask

    task automatic test_load_ext();
        int lat, nwen; logic [31:0] lastw, rd; logic er;
        logic [1:0]  sz [6]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        logic        un [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [6]  = '{32'h302, 32'h302, 32'h302, 32'h300, 32'h301, 32'h300};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                                 32'h00007F01, 32'h0000007F, 32'h00007F01};
        preload(32'h300, 32'h80FF7F01);
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, nwen, lastw, rd, er);
            vecs++;
            if (lat !== 2 || nwen !== 0 || rd !== exp[i]) begin
                errs++;
                $display("FAIL load_ext[%0d]: lat %0d wen %0d rdata %h want 2 0 %h",
                         i, lat, nwen, rd, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, nrsp = 0;
        int acc_cyc [4];
        int rsp_cyc [4];
        logic [31:0] rsp_dat [4];
        logic rsp_rdy [4];
        logic rdy;
        preload(32'h0, 32'h01010101);
        preload(32'h4, 32'h02020202);
        preload(32'h8, 32'h03030303);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0;
        for (int c = 0; c < 12; c++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rsp_valid && nrsp < 4) begin
                rsp_cyc[nrsp] = c; rsp_dat[nrsp] = rsp_rdata; rsp_rdy[nrsp] = req_ready;
                nrsp++;
            end
            if (rdy && req_valid && acc < 4) begin
                acc_cyc[acc] = c;
                acc++;
                req_addr = acc * 4;
                if (acc == 3) req_valid = 1'b0;
            end
            @(negedge clk);
        end
        vecs++;
        if (acc !== 3 || nrsp !== 3) begin
            errs++;
            $display("FAIL b2b_count: accepts %0d responses %0d want 3 3", acc, nrsp);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vecs++;
                if (acc_cyc[i] !== 3 * i || rsp_cyc[i] !== 3 * i + 2 || rsp_rdy[i] !== 1'b1 ||
                    rsp_dat[i] !== {4{8'(i + 1)}}) begin
                    errs++;
                    $display("FAIL b2b[%0d]: acc %0d rsp %0d rdy %b data %h want %0d %0d 1 %h",
                             i, acc_cyc[i], rsp_cyc[i], rsp_rdy[i], rsp_dat[i],
                             3 * i, 3 * i + 2, {4{8'(i + 1)}});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_wen, saw_rv;
        preload(32'h200, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h202; req_wdata = 32'h000000AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        saw_wen = wen; saw_rv = rsp_valid;
        #2 rst_n = 1'b0;
        #1 saw_wen |= wen;
        @(posedge clk); #1;
        saw_wen |= wen; saw_rv |= rsp_valid;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            saw_wen |= wen; saw_rv |= rsp_valid;
        end
        vecs++;
        if (saw_wen !== 1'b0 || saw_rv !== 1'b0 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_ctrl: wen %b valid %b ready %b want 0 0 1",
                     saw_wen, saw_rv, req_ready);
        end
        vecs++;
        if (mem[8'h80] !== 32'h11223344) begin
            errs++;
            $display("FAIL reset_mid_mem: got %h want 11223344", mem[8'h80]);
        end
    endtask

    task automatic test_misalign();
        int lat, nwen; logic [31:0] lastw, rd; logic er;
        run_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, nwen, lastw, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs++;
        if (lat !== 1 || nwen !== 0 || er !== 1'b1 || rd !== 32'h0) begin
            errs++;
            $display("FAIL lw_misalign: lat %0d wen %0d err %b rdata %h want 1 0 1 0",
                     lat, nwen, er, rd);
        end
`else
        vecs++;
        if (lat !== 2 || nwen !== 0 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL lw_misalign: lat %0d wen %0d err %b rdata %h want 2 0 0 deadbeef",
                     lat, nwen, er, rd);
        end
`endif
        run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, nwen, lastw, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            errs++;
            $display("FAIL size11: lat %0d err %b rdata %h want 1 1 0", lat, er, rd);
        end
`else
        vecs++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL size11: lat %0d err %b rdata %h want 2 0 deadbeef", lat, er, rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_store_merge();
        test_load_ext();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
